// File: rtl/speed_select.sv
`default_nettype none
// ============================================================================
// Module      : speed_select
// Description : Push-button speed selector. The raw button is synchronised,
//               sampled on a slow tick and debounced. Each debounced rising
//               edge toggles the speed between slow and fast. After a toggle,
//               further presses are ignored for a lockout period.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SAMPLE_DIV  clk cycles per debounce sample tick          (2 .. 2^24)
//   DB_LEN      consecutive equal samples to change level    (2 .. 16)
//   LOCK_TICKS  sample ticks of lockout after a speed change (1 .. 255)
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn        in   raw bouncing button level (1 = pressed)
//   btn_db     out  debounced button level, registered
//   speed      out  selected speed (0 = slow, 1 = fast), registered
//   speed_chg  out  one-cycle pulse in the cycle speed takes a new value
// ============================================================================
module speed_select #(
    parameter int SAMPLE_DIV = 131072,
    parameter int DB_LEN     = 4,
    parameter int LOCK_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db,
    output logic speed,
    output logic speed_chg
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The sample counter only has to reach SAMPLE_DIV-1, so clog2 of the
    // divider is sufficient (24 bits at the 2^24 maximum).
    localparam int c_CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    // The lock counter has to hold LOCK_TICKS itself, hence the +1.
    localparam int c_LOCK_W = $clog2(LOCK_TICKS + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LOAD = c_LOCK_W'(LOCK_TICKS);
    localparam logic [c_LOCK_W-1:0] c_LOCK_ONE  = c_LOCK_W'(1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_ZERO = '0;

    // Three state bits leave spare encodings; any of those falls back to
    // S_SLOW through the default branch of the next-state logic.
    typedef enum logic [2:0] {
        S_SLOW      = 3'b000,
        S_FAST      = 3'b001,
        S_LOCK_SLOW = 3'b010,
        S_LOCK_FAST = 3'b011
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                r_sync1;
    logic                r_btn_s;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_tick;
    logic [DB_LEN-1:0]   r_shift;
    logic                r_db_d;
    logic                w_press;
    logic [2:0]          r_state;
    state_t              w_state_nxt;
    logic                w_lock_load;
    logic                w_in_lock;
    logic                w_chg_nxt;
    logic                w_speed_nxt;
    logic [c_LOCK_W-1:0] r_lock;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous button input
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_btn_s <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample tick generator: free-running 0 .. SAMPLE_DIV-1
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign w_tick = (r_cnt == c_CNT_MAX);

    // ------------------------------------------------------------------------
    // Debouncer: the level only changes once DB_LEN consecutive samples agree
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_tick) begin
            r_shift <= {r_shift[DB_LEN-2:0], r_btn_s};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b0;
            r_db_d <= 1'b0;
        end else begin
            if (&r_shift) begin
                btn_db <= 1'b1;
            end else if (~|r_shift) begin
                btn_db <= 1'b0;
            end
            r_db_d <= btn_db;
        end
    end

    // Rising edge of the debounced level only; a held button yields one pulse.
    assign w_press = btn_db & ~r_db_d;

    // ------------------------------------------------------------------------
    // Speed FSM - state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_SLOW;
            speed     <= 1'b0;
            speed_chg <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            speed     <= w_speed_nxt;
            speed_chg <= w_chg_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Speed FSM - next state and registered-output precursors
    // ------------------------------------------------------------------------
    // Presses seen in a lock state fall through with no effect, so they are
    // neither acted on nor remembered for later.
    always_comb begin
        w_state_nxt = S_SLOW;
        w_lock_load = 1'b0;
        w_chg_nxt   = 1'b0;
        case (r_state)
            S_SLOW: begin
                if (w_press) begin
                    w_state_nxt = S_LOCK_FAST;
                    w_lock_load = 1'b1;
                    w_chg_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_SLOW;
                end
            end
            S_FAST: begin
                if (w_press) begin
                    w_state_nxt = S_LOCK_SLOW;
                    w_lock_load = 1'b1;
                    w_chg_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_FAST;
                end
            end
            S_LOCK_SLOW: begin
                if (r_lock == c_LOCK_ZERO) begin
                    w_state_nxt = S_SLOW;
                end else begin
                    w_state_nxt = S_LOCK_SLOW;
                end
            end
            S_LOCK_FAST: begin
                if (r_lock == c_LOCK_ZERO) begin
                    w_state_nxt = S_FAST;
                end else begin
                    w_state_nxt = S_LOCK_FAST;
                end
            end
            default: begin
                // Spare encoding: return to slow without signalling a change.
                w_state_nxt = S_SLOW;
            end
        endcase
    end

    // speed is registered from the next state so it moves on the same edge
    // as the state register and the speed_chg pulse.
    assign w_speed_nxt = (w_state_nxt == S_FAST) || (w_state_nxt == S_LOCK_FAST);

    assign w_in_lock = (r_state == S_LOCK_SLOW) || (r_state == S_LOCK_FAST);

    // ------------------------------------------------------------------------
    // Lockout counter: loaded on entry to a lock state, counts ticks down
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= '0;
        end else if (w_lock_load) begin
            r_lock <= c_LOCK_LOAD;
        end else if (w_in_lock && w_tick && (r_lock != c_LOCK_ZERO)) begin
            r_lock <= r_lock - c_LOCK_ONE;
        end
    end

endmodule
`default_nettype wire

// File: doc/speed_select.md
SPEED_SELECT -- requirements
Module: speed_select

Interface
REQ-001 Parameter SAMPLE_DIV, default 131072, meaning clk cycles per debounce sample tick (range 2..2^24).
REQ-002 Parameter DB_LEN, default 4, meaning consecutive equal samples required to change debounced level (range 2..16).
REQ-003 Parameter LOCK_TICKS, default 8, meaning sample ticks during which presses are ignored after a speed change (range 1..255).
REQ-004 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 btn  input  1  raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-007 btn_db  output  1  debounced button level, registered.
REQ-008 speed  output  1  selected speed (0 = slow, 1 = fast), registered; drives the LED sequencer speed input.
REQ-009 speed_chg  output  1  single-cycle pulse, high in the same cycle speed takes its new value.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer before any other use; btn_s denotes the second flop output.
REQ-011 Sample counter SHALL count 0..SAMPLE_DIV-1 and wrap to 0; tick SHALL be high for exactly the one cycle the counter equals SAMPLE_DIV-1.
REQ-012 On each tick, a DB_LEN-bit shift register SHALL shift in btn_s; no shift on non-tick cycles.
REQ-013 btn_db SHALL go 1 on the clock after the shift register becomes all ones, 0 on the clock after it becomes all zeros, and otherwise hold.
REQ-014 press SHALL be an internal one-cycle pulse asserted the cycle after btn_db rises (btn_db & ~btn_db_d); falling edges SHALL produce no pulse.
REQ-015 FSM states: SLOW, FAST, LOCK_SLOW, LOCK_FAST; speed SHALL be 1 in FAST and LOCK_FAST, 0 otherwise.
REQ-016 SLOW + press -> LOCK_FAST; FAST + press -> LOCK_SLOW; the transition, new speed value and speed_chg pulse SHALL occur on the same clock edge, one cycle after press.
REQ-017 On entering a LOCK state a lock counter SHALL load LOCK_TICKS and decrement on each tick; when it reaches 0 the FSM SHALL move LOCK_FAST -> FAST or LOCK_SLOW -> SLOW on the next edge.
REQ-018 press asserted in either LOCK state SHALL be discarded (no toggle, no pulse, not remembered).
REQ-019 A button held continuously SHALL cause exactly one toggle; a further toggle requires btn_db to fall and rise again.
REQ-020 speed_chg SHALL never be high for two consecutive cycles and SHALL be high only on an actual speed change.
REQ-021 Illegal FSM encodings SHALL recover to SLOW on the next clock with speed=0 and no speed_chg pulse.
REQ-022 Counter widths SHALL be sized from parameters with no overflow at the maximum parameter values.

Reset
REQ-023 While rst=1: synchronizer flops, shift register, btn_db, btn_db_d, sample counter and lock counter SHALL be 0; FSM SHALL be SLOW; speed=0; speed_chg=0.
REQ-024 Reset assertion SHALL take effect immediately (asynchronously), including mid-lock and mid-debounce; release SHALL be observed on the first clk rising edge after deassertion.
REQ-025 A button held across reset release SHALL be treated as a new press once debounced (one toggle to FAST).

Verification (SAMPLE_DIV=4, DB_LEN=4, LOCK_TICKS=8 unless stated)
REQ-026 Reset then btn=0 for 100 cycles -> speed=0, btn_db=0, speed_chg never high.
REQ-027 Clean btn=1 held 200 cycles -> btn_db rises within 2+4*5 cycles of btn edge; exactly one speed_chg pulse; speed=1 thereafter.
REQ-028 btn toggling every 3 cycles for 60 cycles, then 0 -> btn_db stays 0, speed unchanged, no speed_chg.
REQ-029 Two clean presses 20 cycles apart (second inside 32-cycle lock) -> single toggle to speed=1; third press after lock expires -> speed=0 with one speed_chg pulse.
REQ-030 rst pulsed while in LOCK_FAST with btn=1 -> speed=0 asynchronously; after release, with btn still 1, one toggle back to speed=1.
REQ-031 Force FSM to an illegal encoding -> next clock speed=0, state SLOW, no speed_chg.
